// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory fill arbiter.
//   - state_t : arbiter FSM states
//   - owner_t : which cache a fill belongs to
//   - widths of addresses, data, word index and block offset
//   - fill_owner(): maps a fill state onto its owning cache
package mem_arb_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int WORDS      = 8;
    localparam int WORD_IDX_W = $clog2(WORDS);
    // Block offset in byte-address terms: word index plus the always-zero byte bit.
    localparam int BLK_OFF_W  = WORD_IDX_W + 1;
    localparam int BASE_W     = ADDR_W - BLK_OFF_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FILL_D = 2'd2,
        FILL_I = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D    = 2'd1,
        OWN_I    = 2'd2
    } owner_t;

    function automatic owner_t fill_owner(input state_t s);
        case (s)
            FILL_D:  return OWN_D;
            FILL_I:  return OWN_I;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_fill_arbiter_if.sv
// Bundle of the cache request lines, the memory bus and the fill return path.
//   master : the arbiter (drives memory bus, fill strobes, acks, busy)
//   slave  : caches + memory model (drive requests, read data, mem_valid)
interface mem_fill_arbiter_if import mem_arb_pkg::*; ();

    // cache requests
    logic                  i_miss;
    logic [ADDR_W-1:0]     i_miss_addr;
    logic                  d_miss;
    logic [ADDR_W-1:0]     d_miss_addr;
    logic                  d_wr;
    logic [ADDR_W-1:0]     d_wr_addr;
    logic [DATA_W-1:0]     d_wr_data;

    // memory bus
    logic                  mem_en;
    logic                  mem_wr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_valid;

    // fill return and status
    logic [DATA_W-1:0]     fill_data;
    logic [WORD_IDX_W-1:0] fill_word;
    logic                  i_fill_we;
    logic                  d_fill_we;
    logic                  i_fill_done;
    logic                  d_fill_done;
    logic                  d_wr_ack;
    logic                  busy;

    modport master (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
        input  d_wr, d_wr_addr, d_wr_data,
        input  mem_rdata, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_data, fill_word, i_fill_we, d_fill_we,
        output i_fill_done, d_fill_done, d_wr_ack, busy
    );

    modport slave (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
        output d_wr, d_wr_addr, d_wr_data,
        output mem_rdata, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_data, fill_word, i_fill_we, d_fill_we,
        input  i_fill_done, d_fill_done, d_wr_ack, busy
    );

endinterface

// File: rtl/mem_fill_arbiter_word_ctr.sv
// word_ctr: word-index counter for block transfers.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : return to 0 (wins over inc_i)
//   inc_i    : advance by one, wrapping at WORDS
//   cnt_o    : current word index
//   last_o   : index is the final word of the block
module word_ctr
    import mem_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [WORD_IDX_W-1:0] cnt_o,
    output logic                  last_o
);

    logic [WORD_IDX_W-1:0] cnt_q;
    logic [WORD_IDX_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == WORD_IDX_W'(WORDS - 1));

endmodule

// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: sequences the single-ported main memory between
// D-side write-through stores, D-cache fills and I-cache fills.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_fill_arbiter_if.master
//              requests  i_miss/d_miss/d_wr (+ addresses, store data)
//              memory    mem_en/mem_wr/mem_addr/mem_wdata out, mem_rdata/mem_valid in
//              fill      fill_data/fill_word, i/d_fill_we, i/d_fill_done pulses
//              status    d_wr_ack pulse, busy
// Fixed priority store > D fill > I fill. Fills issue all block addresses
// back to back and count returned words by mem_valid, so the memory latency
// is not assumed anywhere.
module mem_fill_arbiter
    import mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    mem_fill_arbiter_if.master bus
);

    state_t                state_q, state_d;
    // The transaction that finished last cycle; IDLE means nobody is masked.
    // Lets a requester drop its level one cycle late without being re-granted.
    state_t                mask_q, mask_d;
    logic [BASE_W-1:0]     base_q, base_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]     wr_data_q, wr_data_d;
    // The issue counter wraps after the last word; this flag stops further issues.
    logic                  issue_done_q, issue_done_d;

    logic [WORD_IDX_W-1:0] ic, rc;
    logic                  ic_last, rc_last;
    logic                  ic_inc, ic_clr, rc_inc, rc_clr;
    owner_t                owner;

    logic                  mem_en_o, mem_wr_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o, fill_data_o;
    logic [WORD_IDX_W-1:0] fill_word_o;
    logic                  i_fill_we_o, d_fill_we_o;
    logic                  i_fill_done_o, d_fill_done_o, d_wr_ack_o;

    // Offset bits of miss addresses are irrelevant: fills always start at word 0.
    logic                  unused_offset_bits;
    assign unused_offset_bits = ^{bus.i_miss_addr[BLK_OFF_W-1:0], bus.d_miss_addr[BLK_OFF_W-1:0]};

    word_ctr u_issue_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (ic_clr),
        .inc_i  (ic_inc),
        .cnt_o  (ic),
        .last_o (ic_last)
    );

    word_ctr u_recv_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (rc_clr),
        .inc_i  (rc_inc),
        .cnt_o  (rc),
        .last_o (rc_last)
    );

    assign owner = fill_owner(state_q);

    always_comb begin
        state_d       = state_q;
        mask_d        = IDLE;
        base_d        = base_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        issue_done_d  = issue_done_q;
        ic_inc        = 1'b0;
        ic_clr        = 1'b0;
        rc_inc        = 1'b0;
        rc_clr        = 1'b0;
        mem_en_o      = 1'b0;
        mem_wr_o      = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        fill_data_o   = '0;
        fill_word_o   = '0;
        i_fill_we_o   = 1'b0;
        d_fill_we_o   = 1'b0;
        i_fill_done_o = 1'b0;
        d_fill_done_o = 1'b0;
        d_wr_ack_o    = 1'b0;

        case (state_q)
            IDLE: begin
                ic_clr       = 1'b1;
                rc_clr       = 1'b1;
                issue_done_d = 1'b0;
                if (bus.d_wr && (mask_q != WRITE)) begin
                    state_d   = WRITE;
                    base_d    = bus.d_wr_addr[ADDR_W-1:BLK_OFF_W];
                    wr_addr_d = bus.d_wr_addr;
                    wr_data_d = bus.d_wr_data;
                end else if (bus.d_miss && (mask_q != FILL_D)) begin
                    state_d = FILL_D;
                    base_d  = bus.d_miss_addr[ADDR_W-1:BLK_OFF_W];
                end else if (bus.i_miss && (mask_q != FILL_I)) begin
                    state_d = FILL_I;
                    base_d  = bus.i_miss_addr[ADDR_W-1:BLK_OFF_W];
                end
            end

            WRITE: begin
                mem_en_o    = 1'b1;
                mem_wr_o    = 1'b1;
                mem_addr_o  = wr_addr_q;
                mem_wdata_o = wr_data_q;
                d_wr_ack_o  = 1'b1;
                mask_d      = WRITE;
                state_d     = IDLE;
            end

            FILL_D, FILL_I: begin
                if (!issue_done_q) begin
                    mem_en_o   = 1'b1;
                    mem_addr_o = {base_q, ic, 1'b0};
                    ic_inc     = 1'b1;
                    if (ic_last) begin
                        issue_done_d = 1'b1;
                    end
                end
                if (bus.mem_valid) begin
                    fill_data_o = bus.mem_rdata;
                    fill_word_o = rc;
                    i_fill_we_o = (owner == OWN_I);
                    d_fill_we_o = (owner == OWN_D);
                    rc_inc      = 1'b1;
                    if (rc_last) begin
                        i_fill_done_o = (owner == OWN_I);
                        d_fill_done_o = (owner == OWN_D);
                        mask_d        = state_q;
                        state_d       = IDLE;
                        ic_clr        = 1'b1;
                        rc_clr        = 1'b1;
                        issue_done_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mask_q       <= IDLE;
            base_q       <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            issue_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            base_q       <= base_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            issue_done_q <= issue_done_d;
        end
    end

    assign bus.mem_en      = mem_en_o;
    assign bus.mem_wr      = mem_wr_o;
    assign bus.mem_addr    = mem_addr_o;
    assign bus.mem_wdata   = mem_wdata_o;
    assign bus.fill_data   = fill_data_o;
    assign bus.fill_word   = fill_word_o;
    assign bus.i_fill_we   = i_fill_we_o;
    assign bus.d_fill_we   = d_fill_we_o;
    assign bus.i_fill_done = i_fill_done_o;
    assign bus.d_fill_done = d_fill_done_o;
    assign bus.d_wr_ack    = d_wr_ack_o;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a fixed-latency memory model and
// a cycle-stamped scoreboard of expected issues, fill writes and done pulses.
module tb_mem_fill_arbiter;

    localparam int MEM_LAT = 4;
    localparam int NWORDS  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic inj = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mem_fill_arbiter_if bus ();

    mem_fill_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5AC3;
    endfunction

    // Memory model: a read issued in cycle F returns in cycle F+MEM_LAT.
    logic [MEM_LAT-1:0]       pv;
    logic [MEM_LAT-1:0][15:0] pa;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            pa <= '0;
        end else begin
            pv <= {pv[MEM_LAT-2:0], bus.mem_en & ~bus.mem_wr};
            pa <= {pa[MEM_LAT-2:0], bus.mem_addr};
        end
    end

    assign bus.mem_valid = pv[MEM_LAT-1] | inj;
    assign bus.mem_rdata = inj ? 16'h1357 : (pv[MEM_LAT-1] ? rd_fn(pa[MEM_LAT-1]) : 16'hDEAD);

    typedef struct { int cyc; logic wr; logic [15:0] addr; logic [15:0] data; } iss_t;
    typedef struct { int cyc; logic side; logic [2:0] word; logic [15:0] data; } fill_t;
    typedef struct { int cyc; logic side; } done_t;   // side: 1 = I, 0 = D

    iss_t  iss_q[$];
    fill_t fill_q[$];
    done_t done_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_fill(input logic side, input logic [15:0] req, input int f);
        logic [15:0] a;
        for (int w = 0; w < NWORDS; w++) begin
            a = {req[15:4], 4'h0} | 16'(w * 2);
            iss_q.push_back('{f + w, 1'b0, a, 16'h0});
            fill_q.push_back('{f + MEM_LAT + w, side, 3'(w), rd_fn(a)});
        end
        done_q.push_back('{f + MEM_LAT + NWORDS - 1, side});
    endtask

    // Drop expectations later than now (used when reset cuts a fill short).
    task automatic purge_future();
        while (iss_q.size() > 0 && iss_q[iss_q.size()-1].cyc > cyc) iss_q.delete(iss_q.size()-1);
        while (fill_q.size() > 0 && fill_q[fill_q.size()-1].cyc > cyc) fill_q.delete(fill_q.size()-1);
        while (done_q.size() > 0 && done_q[done_q.size()-1].cyc > cyc) done_q.delete(done_q.size()-1);
    endtask

    task automatic monitor();
        iss_t  ie;
        fill_t fe;
        done_t de;
        while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
            chk("issue_missed", 32'(cyc), 32'(iss_q[0].cyc));
            iss_q.delete(0);
        end
        while (fill_q.size() > 0 && fill_q[0].cyc < cyc) begin
            chk("fill_missed", 32'(cyc), 32'(fill_q[0].cyc));
            fill_q.delete(0);
        end
        while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
            chk("done_missed", 32'(cyc), 32'(done_q[0].cyc));
            done_q.delete(0);
        end
        if (bus.mem_en) begin
            if (iss_q.size() == 0) begin
                chk("issue_unexpected", 32'(bus.mem_en), 32'd0);
            end else begin
                ie = iss_q.pop_front();
                chk("issue_cyc", 32'(cyc), 32'(ie.cyc));
                chk("issue_wr", 32'(bus.mem_wr), 32'(ie.wr));
                chk("issue_addr", 32'(bus.mem_addr), 32'(ie.addr));
                chk("issue_ack", 32'(bus.d_wr_ack), 32'(ie.wr));
                if (ie.wr) chk("write_data", 32'(bus.mem_wdata), 32'(ie.data));
                $display("cyc=%0d issue wr=%0b addr=%h wdata=%h", cyc, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
            end
        end else if (bus.d_wr_ack) begin
            chk("ack_stray", 32'(bus.d_wr_ack), 32'd0);
        end
        if (bus.i_fill_we || bus.d_fill_we) begin
            if (fill_q.size() == 0) begin
                chk("fill_unexpected", 32'({bus.i_fill_we, bus.d_fill_we}), 32'd0);
            end else begin
                fe = fill_q.pop_front();
                chk("fill_cyc", 32'(cyc), 32'(fe.cyc));
                chk("fill_side", 32'({bus.i_fill_we, bus.d_fill_we}), 32'({fe.side, ~fe.side}));
                chk("fill_word", 32'(bus.fill_word), 32'(fe.word));
                chk("fill_data", 32'(bus.fill_data), 32'(fe.data));
                $display("cyc=%0d fill i=%0b d=%0b word=%0d data=%h", cyc, bus.i_fill_we, bus.d_fill_we, bus.fill_word, bus.fill_data);
            end
        end
        if (bus.i_fill_done || bus.d_fill_done) begin
            if (done_q.size() == 0) begin
                chk("done_unexpected", 32'({bus.i_fill_done, bus.d_fill_done}), 32'd0);
            end else begin
                de = done_q.pop_front();
                chk("done_cyc", 32'(cyc), 32'(de.cyc));
                chk("done_side", 32'({bus.i_fill_done, bus.d_fill_done}), 32'({de.side, ~de.side}));
                $display("cyc=%0d done i=%0b d=%0b", cyc, bus.i_fill_done, bus.d_fill_done);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        monitor();
    endtask

    task automatic run_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'({bus.mem_en, bus.mem_wr, bus.i_fill_we, bus.d_fill_we,
                                bus.i_fill_done, bus.d_fill_done, bus.d_wr_ack, bus.busy}), 32'd0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(bus.mem_wdata), 32'd0);
        chk({tag, "_fdata"}, 32'(bus.fill_data), 32'd0);
        chk({tag, "_fword"}, 32'(bus.fill_word), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int f;
        int fd;
        int fi;

        bus.i_miss = 1'b0; bus.i_miss_addr = '0;
        bus.d_miss = 1'b0; bus.d_miss_addr = '0;
        bus.d_wr   = 1'b0; bus.d_wr_addr   = '0; bus.d_wr_data = '0;

        // Reset state
        repeat (3) step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        // I fill of 0x0346; requester holds its level one cycle past done
        bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0346;
        f = cyc + 1;
        expect_fill(1'b1, 16'h0346, f);
        step();
        chk("t1_busy", 32'(bus.busy), 32'd1);
        run_until(f + 12);
        chk("t1_busy_fall", 32'(bus.busy), 32'd0);
        step();
        chk("t1_mask_idle", 32'(bus.busy), 32'd0);
        bus.i_miss = 1'b0;
        step();

        // D and I miss together: D first, I after one IDLE cycle
        bus.d_miss = 1'b1; bus.d_miss_addr = 16'h1238;
        bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0020;
        fd = cyc + 1;
        fi = fd + 13;
        expect_fill(1'b0, 16'h1238, fd);
        expect_fill(1'b1, 16'h0020, fi);
        run_until(fd + 12);
        chk("t2_idle_between", 32'(bus.busy), 32'd0);
        step();
        chk("t2_i_started", 32'(bus.busy), 32'd1);
        bus.d_miss = 1'b0;
        run_until(fi + 12);
        chk("t2_busy_fall", 32'(bus.busy), 32'd0);
        step();
        bus.i_miss = 1'b0;
        step();

        // Store and D miss together: write first, then the fill
        c = cyc;
        bus.d_wr = 1'b1; bus.d_wr_addr = 16'h4002; bus.d_wr_data = 16'hBEEF;
        bus.d_miss = 1'b1; bus.d_miss_addr = 16'h4002;
        iss_q.push_back('{c + 1, 1'b1, 16'h4002, 16'hBEEF});
        f = c + 3;
        expect_fill(1'b0, 16'h4002, f);
        step();
        step();
        chk("t3_idle_after_ack", 32'(bus.busy), 32'd0);
        step();
        bus.d_wr = 1'b0;
        run_until(f + 12);
        chk("t3_busy_fall", 32'(bus.busy), 32'd0);
        step();
        bus.d_miss = 1'b0;
        step();

        // Request changed and dropped mid-fill: fill still completes on old base
        bus.i_miss = 1'b1; bus.i_miss_addr = 16'h5A5C;
        f = cyc + 1;
        expect_fill(1'b1, 16'h5A5C, f);
        step();
        step();
        bus.i_miss_addr = 16'hFFF0;
        bus.i_miss = 1'b0;
        run_until(f + 12);
        chk("t4_busy_fall", 32'(bus.busy), 32'd0);
        step();

        // Reset at F+6 of a D fill
        bus.d_miss = 1'b1; bus.d_miss_addr = 16'h7778;
        f = cyc + 1;
        expect_fill(1'b0, 16'h7778, f);
        run_until(f + 6);
        #1;
        rst = 1'b1;
        bus.d_miss = 1'b0;
        #1;
        chk_zero("midfill_rst");
        purge_future();
        step();
        rst = 1'b0;
        step();
        bus.i_miss = 1'b1; bus.i_miss_addr = 16'h2468;
        f = cyc + 1;
        expect_fill(1'b1, 16'h2468, f);
        run_until(f + 12);
        chk("t5_busy_fall", 32'(bus.busy), 32'd0);
        step();
        bus.i_miss = 1'b0;
        step();

        // Stray mem_valid while IDLE
        inj = 1'b1;
        #1;
        chk("idle_valid_we", 32'({bus.i_fill_we, bus.d_fill_we}), 32'd0);
        chk("idle_valid_done", 32'({bus.i_fill_done, bus.d_fill_done}), 32'd0);
        chk("idle_valid_fdata", 32'(bus.fill_data), 32'd0);
        inj = 1'b0;
        step();
        chk("idle_valid_state", 32'(bus.busy), 32'd0);

        repeat (6) step();
        chk("left_issues", 32'(iss_q.size()), 32'd0);
        chk("left_fills", 32'(fill_q.size()), 32'd0);
        chk("left_dones", 32'(done_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_fill_arbiter.md
Name: mem_fill_arbiter

Overview:
- Sequences the single-ported main memory shared by the I-cache and D-cache of the 5-stage pipeline.
- Arbitrates three requesters: D-side write-through stores, D-cache miss fills and I-cache miss fills.
- Fills are 8-word block transfers: addresses are issued back to back and returned words are counted in.
- Sits between the two cache tag/data arrays and the multi-cycle memory model; the pipeline stalls on busy/miss.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data word width.
- WORDS, 8, words per cache block (power of 2).
- MEM_LAT, 4, memory read latency in cycles from issue to mem_valid (bench model only; the RTL counts mem_valid and does not hard-code the latency).

Ports:
- clk in 1: clock.
- rst in 1: asynchronous, active-high reset.
- i_miss in 1: I-cache miss, level; held until i_fill_done.
- i_miss_addr in 16: I miss address.
- d_miss in 1: D-cache miss, level; held until d_fill_done.
- d_miss_addr in 16: D miss address.
- d_wr in 1: write-through store request, level; held until d_wr_ack.
- d_wr_addr in 16: store address.
- d_wr_data in 16: store data.
- mem_en out 1: memory access enable.
- mem_wr out 1: memory write.
- mem_addr out 16: memory address.
- mem_wdata out 16: memory write data.
- mem_rdata in 16: memory read data.
- mem_valid in 1: mem_rdata valid this cycle.
- fill_data out 16: word to write into the owning cache.
- fill_word out 3: word index within the block.
- i_fill_we out 1: write fill_data into the I-cache.
- d_fill_we out 1: write fill_data into the D-cache.
- i_fill_done out 1: one-cycle pulse when the I block is complete.
- d_fill_done out 1: one-cycle pulse when the D block is complete.
- d_wr_ack out 1: one-cycle pulse when the store is issued.
- busy out 1: state != IDLE.

Behaviour:
- States: IDLE, WRITE, FILL_D, FILL_I.
- Reset: state IDLE, all counters 0. All outputs are 0, including mem_addr, mem_wdata, fill_data and fill_word.

IDLE arbitration (fixed priority) at each edge:
- d_wr -> WRITE.
- else d_miss -> FILL_D.
- else i_miss -> FILL_I.
- On grant, latch base = addr[15:4]. For WRITE, also latch the store address and data. Later changes on the request inputs are ignored.
- Owner mask: in the single IDLE cycle immediately after a done/ack, the requester that just finished is not eligible. This covers the requester's one-cycle deassert slack.

WRITE:
- One cycle with mem_en=1, mem_wr=1, mem_addr/mem_wdata from the latches, and d_wr_ack=1.
- Next state IDLE.

FILL_x:
- Issue counter ic runs 0..7. On each FILL cycle while ic<8: mem_en=1, mem_wr=0, mem_addr={base, ic, 1'b0}, ic++.
- Receive counter rc: each mem_valid pulse drives fill_data=mem_rdata, fill_word=rc and x_fill_we=1, then rc++.
- On the cycle rc==7 and mem_valid: also pulse x_fill_done. Next state IDLE; both counters clear.
- With MEM_LAT=4 and first issue cycle F: fill_we occurs at F+4..F+11, done at F+11, busy falls at F+12.

Boundary conditions:
- A request dropped mid-transaction does not abort it; the fill completes and done still pulses.
- mem_valid while in IDLE or WRITE, or after rc has wrapped, is ignored (no fill_we).
- Simultaneous d_miss and i_miss: D is served first. I is granted in the IDLE cycle after d_fill_done.
- d_wr and d_miss together: the write goes first, then the fill.
- Reset mid-fill: immediate return to IDLE and outputs 0. The memory model is reset by the same rst, so no stale data is counted.
- Address arithmetic: word address only; bit 0 of mem_addr is always 0 during fills. No carry out of the base.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, WRITE, FILL_D, FILL_I);
  - the owner encoding (OWN_NONE, OWN_D, OWN_I);
  - localparams WORDS, WORD_IDX_W = log2(WORDS) and BLK_OFF_W = WORD_IDX_W+1.
- One sub-module, word_ctr: a WORD_IDX_W-bit counter with inc, clear and a last-word flag. It is instantiated twice, for issue and for receive.

Test Plan:
- Reset, then i_miss=1, i_miss_addr=16'h0346 -> mem_addr 16'h0340, 0342, …, 034E on 8 consecutive cycles. i_fill_we with fill_word 0..7 at F+4..F+11, i_fill_done at F+11, busy low at F+12.
- d_miss(16'h1238) and i_miss(16'h0020) raised in the same cycle -> D fill of 16'h1230..123E completes first. I fill of 16'h0020..002E starts on the cycle after d_fill_done plus the IDLE cycle.
- d_wr=1, addr 16'h4002, data 16'hBEEF, with d_miss also high -> a single mem_wr cycle writing 16'hBEEF at 16'h4002 with d_wr_ack. The D fill follows.
- During FILL_I, change i_miss_addr to 16'hFFF0 and drop i_miss after 2 cycles -> addresses stay on the original base, and all 8 words plus done still occur.
- Assert rst at F+6 of a fill -> outputs 0 immediately and busy=0. A new request after reset is granted and completes normally, with no extra fill_we.
- Inject a mem_valid pulse while IDLE -> no fill_we and state unchanged.
